// File: rtl/io_pkg.sv
// Shared constants and types for the processor I/O bridge.
// Word width, default FIFO geometry and the idle input word.
package io_pkg;

    localparam int IO_WORD_W = 16;
    localparam int IO_DEPTH  = 4;
    localparam int IO_PTR_W  = 2;

    typedef logic [IO_WORD_W-1:0] io_word_t;

    localparam io_word_t IO_IDLE_WORD = 16'h0000;

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers.
// Head is visible combinationally; push/pop act on the clock edge.
module io_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WORD_W,
    parameter int DEPTH = IO_DEPTH,
    parameter int PTR_W = IO_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Extra top bit separates a full ring from an empty one.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    // Pointer update; the caller guarantees no push into a full
    // FIFO unless a pop happens in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; cleared on reset so stale words never leak out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/io_bridge.sv
// Bridge between the processor ioOut/ioIn buses and a device
// valid/ready channel pair, with a stall back to the control unit.
module io_bridge
    import io_pkg::*;
#(
    parameter int DEPTH = IO_DEPTH,
    parameter int PTR_W = IO_PTR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_wr,
    input  logic                 io_rd,
    input  logic [IO_WORD_W-1:0] ioOut,
    output logic [IO_WORD_W-1:0] ioIn,
    output logic                 io_stall,
    output logic [IO_WORD_W-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [IO_WORD_W-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [PTR_W:0]       tx_count,
    output logic [PTR_W:0]       rx_count
);

    logic     tx_push;
    logic     tx_pop;
    logic     tx_full;
    logic     tx_empty;
    logic     rx_push;
    logic     rx_pop;
    logic     rx_full;
    logic     rx_empty;
    io_word_t rx_head;

    // Transmit side: a pop frees a slot in the same cycle, so a
    // write into a full FIFO still lands when the device drains.
    always_comb begin
        tx_valid = !tx_empty;
        tx_pop   = tx_valid && tx_ready;
        tx_push  = io_wr && (!tx_full || tx_pop);
    end

    // Receive side: rx_ready comes from registered occupancy only,
    // never from io_rd, to keep the device handshake path short.
    always_comb begin
        rx_ready = !rx_full;
        rx_push  = rx_valid && rx_ready;
        rx_pop   = io_rd && !rx_empty;
        ioIn     = rx_empty ? IO_IDLE_WORD : rx_head;
    end

    // Processor holds state while either request cannot complete.
    always_comb begin
        io_stall = (io_wr && tx_full && !tx_pop) ||
                   (io_rd && rx_empty);
    end

    io_fifo #(
        .WIDTH (IO_WORD_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (ioOut),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    io_fifo #(
        .WIDTH (IO_WORD_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge against a queue-based model.
// Directed test-plan sequences followed by randomized traffic.
module tb_io_bridge;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] ioOut;
    logic [15:0] ioIn;
    logic        io_stall;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [PTR_W:0] tx_count;
    logic [PTR_W:0] rx_count;

    io_bridge #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .ioOut    (ioOut),
        .ioIn     (ioIn),
        .io_stall (io_stall),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_count (tx_count),
        .rx_count (rx_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic [15:0] dev_got[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected outputs straight from queue occupancy.
    task automatic compare_all();
        logic stall_exp;
        stall_exp = (io_wr && txq.size() == DEPTH && !tx_ready) ||
                    (io_rd && rxq.size() == 0);
        check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0)
            check("tx_data", 32'(tx_data), 32'(txq[0]));
        check("rx_ready", 32'(rx_ready), 32'(rxq.size() < DEPTH));
        check("ioIn", 32'(ioIn),
              rxq.size() != 0 ? 32'(rxq[0]) : 32'h0);
        check("io_stall", 32'(io_stall), 32'(stall_exp));
        check("tx_count", 32'(tx_count), 32'(txq.size()));
        check("rx_count", 32'(rx_count), 32'(rxq.size()));
    endtask

    // Check, advance the model by one edge, then return at negedge.
    task automatic cycle();
        logic tp;
        logic tpush;
        logic rpush;
        logic rpop;
        #1;
        compare_all();
        tp    = (txq.size() != 0) && tx_ready;
        tpush = io_wr && (txq.size() < DEPTH || tp);
        rpush = rx_valid && (rxq.size() < DEPTH);
        rpop  = io_rd && (rxq.size() != 0);
        if (tp) begin
            dev_got.push_back(txq[0]);
            void'(txq.pop_front());
        end
        if (tpush)
            txq.push_back(ioOut);
        if (rpop)
            void'(rxq.pop_front());
        if (rpush)
            rxq.push_back(rx_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic wr, input logic [15:0] wd,
                         input logic rd, input logic tr,
                         input logic rv, input logic [15:0] rdat);
        io_wr    = wr;
        ioOut    = wd;
        io_rd    = rd;
        tx_ready = tr;
        rx_valid = rv;
        rx_data  = rdat;
        cycle();
    endtask

    initial begin
        reset    = 1'b1;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        ioOut    = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        @(negedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a pending transmit word.
        drive(1, 16'hABCD, 0, 0, 1, 16'h5A5A);
        io_wr    = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        txq.delete();
        rxq.delete();
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_count", 32'(tx_count), 32'h0);
        check("rst_ioIn", 32'(ioIn), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Transmit ordering with a full FIFO and a same-cycle swap.
        dev_got.delete();
        for (int i = 1; i <= 4; i++)
            drive(1, 16'(i), 0, 0, 0, 0);
        drive(1, 16'h0005, 0, 0, 0, 0);
        drive(1, 16'h0005, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++)
            drive(0, 0, 0, 1, 0, 0);
        check("tx_order_n", 32'(dev_got.size()), 32'd5);
        for (int i = 0; i < 5 && i < dev_got.size(); i++)
            check("tx_order", 32'(dev_got[i]), 32'(i + 1));

        // Receive ordering and return to the idle word.
        drive(0, 0, 0, 0, 1, 16'h1111);
        drive(0, 0, 0, 0, 1, 16'h2222);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Empty-read stall, released one cycle after data lands.
        for (int i = 0; i < 3; i++)
            drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 16'hBEEF);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Receive backpressure at full occupancy.
        for (int i = 0; i < 4; i++)
            drive(0, 0, 0, 0, 1, 16'h3000 + 16'(i));
        drive(0, 0, 0, 0, 1, 16'h3004);
        drive(0, 0, 1, 0, 1, 16'h3004);
        drive(0, 0, 0, 0, 1, 16'h3004);
        for (int i = 0; i < 6; i++)
            drive(0, 0, 1, 0, 0, 0);

        // Randomized concurrent traffic on both channels.
        dev_got.delete();
        for (int i = 0; i < 1000; i++)
            drive($urandom_range(0, 3) != 0, 16'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom),
                  1'($urandom), 16'($urandom));
        for (int i = 0; i < 8; i++)
            drive(0, 0, 1, 1, 0, 0);
        check("drain_tx", 32'(tx_count), 32'h0);
        check("drain_rx", 32'(rx_count), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Device-side counterpart to the processor's I/O datapath. Receives words the processor emits on its ioOut bus and delivers them to an external device over a valid/ready transmit channel.
- Accepts words from the device over a valid/ready receive channel and presents them to the processor on its ioIn bus.
- Both directions are buffered by small FIFOs. A stall output freezes the processor's control unit when an I/O instruction cannot complete.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, minimum 2.
- PTR_W, 2: log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_wr  input  1  control unit requests output of ioOut this cycle.
- io_rd  input  1  control unit requests consumption of ioIn this cycle.
- ioOut  input  16  processor output word.
- ioIn  output  16  processor input word.
- io_stall  output  1  requested I/O cannot complete this cycle; processor holds state.
- tx_data  output  16  word to device.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  device accepts tx_data.
- rx_data  input  16  word from device.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  bridge can accept rx_data.
- tx_count  output  PTR_W+1  occupancy of transmit FIFO.
- rx_count  output  PTR_W+1  occupancy of receive FIFO.

Behaviour:
- Reset (asynchronous, immediate, mid-transfer included):
  - Both FIFOs empty and pointers zero; stored data discarded.
  - tx_valid=0, rx_ready=1, ioIn=16'h0000, io_stall=0, counts=0.
- Each FIFO is first-word-fall-through:
  - Head is visible combinationally while non-empty.
  - Push and pop each take effect at the clock edge.
  - Count = wr_ptr - rd_ptr, computed with one extra wrap bit.
- Transmit path:
  - tx_valid = tx FIFO not empty; tx_data = head.
  - Pop when tx_valid && tx_ready.
  - Push when io_wr && (not full, or pop in the same cycle). Simultaneous push+pop when full is legal and keeps count at DEPTH.
  - io_wr while full without a pop: no push; io_stall=1.
  - tx_data must stay stable while tx_valid && !tx_ready.
- Receive path:
  - rx_ready = rx FIFO not full, computed from registered state only; no combinational path from io_rd.
  - Push when rx_valid && rx_ready.
  - ioIn = head when non-empty, else 16'h0000.
  - Pop when io_rd && not empty.
  - io_rd while empty: io_stall=1, no pop. The processor retries next cycle; data pushed this cycle is visible next cycle, giving one-cycle minimum stall.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged.
- io_stall = (io_wr && tx_full && !tx_pop) || (io_rd && rx_empty). Combinational; zero cycles when neither request is pending.
- io_wr and io_rd asserted together: handled independently; io_stall is the OR of both conditions.
- Latency:
  - ioOut to tx_valid: 1 cycle.
  - rx_data accepted to ioIn visible: 1 cycle.
- Pointers wrap modulo DEPTH; the extra bit distinguishes full from empty.
- No data is ever dropped or duplicated. Overflow is prevented by stall on the processor side and by rx_ready on the device side.

Decomposition:
- Shared package io_pkg:
  - IO_WORD_W=16.
  - Default DEPTH and PTR_W constants.
  - IO_IDLE_WORD=16'h0000.
- One sub-module io_fifo (parameters WIDTH, DEPTH, PTR_W; ports clk, reset, push, pop, din, dout, full, empty, count), instantiated twice: tx and rx.
- io_bridge holds only handshake and stall logic.

Test Plan:
- Reset mid-transfer: push 16'hABCD via io_wr, tx_ready=0, assert reset mid-cycle -> tx_valid falls immediately; tx_count=0; ioIn=16'h0000; rx_ready=1.
- TX order: io_wr with 16'h0001..16'h0004, tx_ready=0 -> tx_count=4, no stall.
  - Fifth io_wr 16'h0005 -> io_stall=1.
  - Raise tx_ready -> 0005 accepted in the same cycle as the 0001 pop.
  - Device receives 0001..0005 in order.
- RX order: device sends 16'h1111, 16'h2222 -> ioIn=16'h1111 one cycle after acceptance.
  - io_rd -> ioIn=16'h2222.
  - io_rd again -> ioIn=16'h0000, rx_count=0.
- RX empty stall: io_rd with FIFO empty for 3 cycles -> io_stall=1 each cycle.
  - Device sends 16'hBEEF -> next cycle io_stall=0, ioIn=16'hBEEF.
- RX full backpressure: device sends 4 words without io_rd -> rx_ready=0, rx_count=4.
  - io_rd -> rx_ready=1 next cycle.
  - Fifth word arrives only afterwards, no loss.
- Concurrent traffic: io_wr and io_rd every cycle, random tx_ready/rx_valid for 1000 cycles -> scoreboard matches both streams exactly; io_stall only under the stated conditions.
